// File: rtl/data_mem_responder_if.sv
// Byte-serial data-memory bus between execute (master) and responder (slave).
// Carries address/write/data, read-back byte, TX console stream and error flag.
interface data_mem_responder_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [31:0]           i_mem_addr;
  logic                  i_mem_write;
  logic [DATA_WIDTH-1:0] i_mem_data;
  logic [DATA_WIDTH-1:0] o_mem_data;
  logic [7:0]            o_tx_data;
  logic                  o_tx_valid;
  logic                  i_tx_ready;
  logic                  o_err;

  modport master (
    output i_mem_addr, i_mem_write, i_mem_data, i_tx_ready,
    input  o_mem_data, o_tx_data, o_tx_valid, o_err
  );

  modport slave (
    input  i_mem_addr, i_mem_write, i_mem_data, i_tx_ready,
    output o_mem_data, o_tx_data, o_tx_valid, o_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: byte RAM plus MMIO window (TX FIFO, STATUS, counter snapshot).
// Ports: i_clk, i_rst (sync, active-high), bus (slave modport). Option: DMEM_COUNTER_EN.
module data_mem_responder #(
  parameter int unsigned RAM_DEPTH     = 4096,
  parameter logic [31:0] MMIO_BASE     = 32'h8000_0000,
  parameter int unsigned TX_FIFO_DEPTH = 8,
  parameter int unsigned DATA_WIDTH    = 8
) (
  input logic                 i_clk,
  input logic                 i_rst,
  data_mem_responder_if.slave bus
);

  localparam int AW = $clog2(RAM_DEPTH);
  localparam int PW = $clog2(TX_FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(TX_FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] ram_q [RAM_DEPTH];
  logic [7:0]            fifo_q [TX_FIFO_DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  logic [31:0]   off;
  logic [AW-1:0] ram_idx;
  logic [2:0]    reg_sel;
  logic          in_ram, in_mmio;
  logic          empty, full, pop;
  logic          push_req, push;
  logic          ram_we, oor_we, stat_we;
  logic [7:0]    mmio_rd;

  // Unsigned wrap makes addresses below the base fall outside the window.
  assign off     = bus.i_mem_addr - MMIO_BASE;
  assign in_ram  = bus.i_mem_addr < 32'(RAM_DEPTH);
  assign in_mmio = !in_ram && (off[31:3] == 29'd0);
  assign reg_sel = off[2:0];
  assign ram_idx = bus.i_mem_addr[AW-1:0];

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == FULL_CNT);
  assign pop   = !empty && bus.i_tx_ready;

  assign push_req = bus.i_mem_write && in_mmio && (reg_sel == 3'd0);
  // A full FIFO still accepts a push when the head leaves the same cycle.
  assign push     = push_req && (!full || pop);
  assign ram_we   = bus.i_mem_write && in_ram;
  assign oor_we   = bus.i_mem_write && !in_ram && !in_mmio;
  assign stat_we  = bus.i_mem_write && in_mmio && (reg_sel == 3'd1);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    if (stat_we && bus.i_mem_data[2]) err_d = 1'b0;
    if (oor_we || (push_req && !push)) err_d = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  // Storage arrays carry no reset; RAM survives i_rst.
  always_ff @(posedge i_clk) begin
    if (ram_we) ram_q[ram_idx] <= bus.i_mem_data;
    if (push)   fifo_q[wr_ptr_q] <= bus.i_mem_data[7:0];
  end

`ifdef DMEM_COUNTER_EN
  logic        snap_we;
  logic [31:0] tick_q, snap_q;

  assign snap_we = bus.i_mem_write && in_mmio && (reg_sel == 3'd4);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tick_q <= '0;
      snap_q <= '0;
    end else begin
      tick_q <= tick_q + 32'd1;
      if (snap_we) snap_q <= tick_q;
    end
  end
`endif

  always_comb begin
    mmio_rd = 8'h00;
    case (reg_sel)
      3'd1:    mmio_rd = {5'b0, err_q, empty, full};
`ifdef DMEM_COUNTER_EN
      3'd4:    mmio_rd = snap_q[7:0];
      3'd5:    mmio_rd = snap_q[15:8];
      3'd6:    mmio_rd = snap_q[23:16];
      3'd7:    mmio_rd = snap_q[31:24];
`endif
      default: mmio_rd = 8'h00;
    endcase
  end

  always_comb begin
    bus.o_mem_data = '0;
    unique case (1'b1)
      in_ram:  bus.o_mem_data = ram_q[ram_idx];
      in_mmio: bus.o_mem_data = DATA_WIDTH'(mmio_rd);
      default: bus.o_mem_data = '0;
    endcase
  end

  assign bus.o_tx_valid = !empty;
  assign bus.o_tx_data  = empty ? 8'h00 : fifo_q[rd_ptr_q];
  assign bus.o_err      = err_q;

endmodule
